// File: rtl/dc_offset_remover.sv
// Sample scaler and DC offset remover: block-average calibration, then saturated subtraction.
// Define DC_TRACK_EN to add leaky-integrator tracking of offset drift while in RUN.
module dc_offset_remover #(
    parameter int SHIFT_IN    = 1,
    parameter int CAL_LOG2    = 7,
    parameter int TRACK_SHIFT = 10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ready_in,
    input  logic [15:0] x_in,
    input  logic        recal_in,
    output logic        ready_out,
    output logic [15:0] y_out,
    output logic [15:0] offset_out,
    output logic        calibrated_out
);
    typedef enum logic {CAL, RUN} state_t;

    localparam int AW = 16 + CAL_LOG2;
    localparam logic [CAL_LOG2:0] CAL_LAST = (CAL_LOG2+1)'((2**CAL_LOG2) - 1);

    state_t state, state_nx;

    logic signed [15:0]   x_s;
    logic signed [AW-1:0] cal_acc, cal_sum;
    logic [CAL_LOG2:0]    cal_cnt;
    logic signed [15:0]   cal_off;
    logic signed [16:0]   diff;
    logic [15:0]          y_sat;
    logic                 cal_done, run_take;

    assign x_s      = $signed(x_in) >>> SHIFT_IN;
    assign cal_sum  = cal_acc + AW'(x_s);
    assign cal_off  = 16'(cal_sum >>> CAL_LOG2);
    assign cal_done = !recal_in && ready_in && (state == CAL) && (cal_cnt == CAL_LAST);
    assign run_take = !recal_in && ready_in && (state == RUN);

    // 17-bit difference cannot overflow; clamp back into 16 bits
    assign diff  = 17'(x_s) - 17'($signed(offset_out));
    assign y_sat = (diff[16] != diff[15]) ? (diff[16] ? 16'h8000 : 16'h7fff) : diff[15:0];

`ifdef DC_TRACK_EN
    localparam int OW = 17 + TRACK_SHIFT;
    logic signed [OW-1:0] off_acc, off_sum;
    logic signed [15:0]   track_off;

    assign off_sum   = off_acc + OW'(diff);
    assign track_off = 16'(off_sum >>> TRACK_SHIFT);

    always_ff @(posedge clk_in) begin
        if (rst_in)
            off_acc <= '0;
        else if (cal_done)
            off_acc <= {cal_off[15], cal_off, {TRACK_SHIFT{1'b0}}};
        else if (run_take)
            off_acc <= off_sum;
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= CAL;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (recal_in)      state_nx = CAL;
        else if (cal_done) state_nx = RUN;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_out      <= 1'b0;
            y_out          <= '0;
            offset_out     <= '0;
            calibrated_out <= 1'b0;
            cal_acc        <= '0;
            cal_cnt        <= '0;
        end else begin
            ready_out <= 1'b0;
            if (recal_in) begin
                // a coincident sample becomes calibration sample 0
                calibrated_out <= 1'b0;
                cal_acc        <= ready_in ? AW'(x_s) : '0;
                cal_cnt        <= ready_in ? (CAL_LOG2+1)'(1) : '0;
            end else if (cal_done) begin
                offset_out     <= cal_off;
                calibrated_out <= 1'b1;
                cal_acc        <= '0;
                cal_cnt        <= '0;
            end else if (ready_in && state == CAL) begin
                cal_acc <= cal_sum;
                cal_cnt <= cal_cnt + 1'b1;
            end else if (run_take) begin
                y_out     <= y_sat;
                ready_out <= 1'b1;
`ifdef DC_TRACK_EN
                offset_out <= track_off;
`endif
            end
        end
    end
endmodule
